// File: rtl/rom_read_sequencer_if.sv
// Bus bundle for rom_read_sequencer.
//   start/base_addr/length : burst request (sampled in IDLE)
//   busy/done              : burst status
//   rom_en/rom_addr        : read strobe and address to a synchronous ROM
//   rom_dout               : ROM data, valid one cycle after rom_en
//   out_*                  : valid/ready word stream to the consumer
// The slave modport is the sequencer; the master modport is its environment.
interface rom_read_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;
  logic                  rom_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_dout;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output start, base_addr, length, rom_dout, out_ready,
    input  busy, done, rom_en, rom_addr, out_data, out_valid, out_last
  );

  modport slave (
    input  start, base_addr, length, rom_dout, out_ready,
    output busy, done, rom_en, rom_addr, out_data, out_valid, out_last
  );
endinterface

// File: rtl/rom_read_sequencer.sv
// Reads a burst of consecutive words from a synchronous ROM and streams them
// to a valid/ready consumer through a 2-entry FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rom_read_sequencer_if.slave (request, status, ROM, stream)
// rom_en is a combinational function of registered state and out_ready so a
// full FIFO can still issue in the cycle it drains a word (1 word/cycle).
module rom_read_sequencer #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rom_read_sequencer_if.slave   bus
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      issued_q, issued_d;
  logic [CNT_W-1:0]      delivered_q, delivered_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  logic                  fifo_valid_c;
  logic                  xfer_c;
  logic                  last_c;
  logic [1:0]            fill_c;
  logic                  rom_en_c;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      inflight_q  <= inflight_d;
      mem_q[0]    <= mem_d[0];
      mem_q[1]    <= mem_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Next-state, issue and FIFO control.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    mem_d[0]    = mem_q[0];
    mem_d[1]    = mem_q[1];
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    fifo_valid_c = (count_q != 2'd0);
    xfer_c       = fifo_valid_c && bus.out_ready;
    last_c       = (CNT_W'(delivered_q + CNT_W'(1)) == len_q);
    // Words already committed to FIFO space: stored plus the one in flight.
    fill_c       = 2'(count_q + 2'(inflight_q));
    rom_en_c     = (state_q == READ) && (issued_q != len_q) &&
                   ((fill_c < 2'd2) || ((fill_c == 2'd2) && xfer_c));
    inflight_d   = rom_en_c;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d      = bus.base_addr;
          len_d       = bus.length;
          issued_d    = '0;
          delivered_d = '0;
          state_d     = (bus.length == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (rom_en_c) begin
          addr_d   = ADDR_WIDTH'(addr_q + ADDR_WIDTH'(1));
          issued_d = CNT_W'(issued_q + CNT_W'(1));
        end
        if (xfer_c) begin
          delivered_d = CNT_W'(delivered_q + CNT_W'(1));
          if (last_c) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // ROM data lands one cycle after its strobe; a cleared inflight_q after
    // reset is what drops data returning from an abandoned burst.
    if (inflight_q) begin
      mem_d[wr_ptr_q] = bus.rom_dout;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (xfer_c) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = 2'(count_q + 2'(inflight_q) - 2'(xfer_c));
  end

  assign bus.busy      = (state_q == READ);
  assign bus.done      = (state_q == DONE);
  assign bus.rom_en    = rom_en_c;
  assign bus.rom_addr  = addr_q;
  assign bus.out_valid = fifo_valid_c;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_last  = fifo_valid_c && last_c;

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Scoreboard bench for rom_read_sequencer: bursts push expected addresses and
// words into queues; a negedge monitor pops and compares as the DUT presents
// rom_en and accepted output words, and checks issue/valid/stability rules.
module tb_rom_read_sequencer;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = AW + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rom_read_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rom_read_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic [DW-1:0] rom [16];
  word_t         exp_word_q [$];
  logic [AW-1:0] exp_addr_q [$];

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Monitor-owned observation counters and cycle logs.
  int   en_count    = 0;
  int   xfer_count  = 0;
  int   done_count  = 0;
  int   busy_count  = 0;
  int   en_cyc_log   [256];
  int   xfer_cyc_log [256];
  int   done_cyc_log [64];
  logic en_last    = 1'b0;
  logic stall_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;
  logic          last_prev = 1'b0;

  // Burst-owned context read by the monitor.
  int en_base   = 0;
  int xfer_base = 0;
  int cur_len   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic ready_for(input int mode, input int k);
    return (mode == 0) || ((k % 3) == 0);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM model.
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_dout <= rom[bus.rom_addr];
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    int     outstanding;
    int     fifo_n;
    logic   exp_en;
    logic   xfer;
    word_t  w;
    logic [AW-1:0] a;
    if (!rst_n) begin
      en_last    = 1'b0;
      stall_prev = 1'b0;
    end else begin
      xfer = bus.out_valid && bus.out_ready;
      if (bus.busy) begin
        busy_count++;
        outstanding = (en_count - en_base) - (xfer_count - xfer_base);
        fifo_n      = outstanding - int'(en_last);
        exp_en = ((en_count - en_base) < cur_len) &&
                 ((outstanding < 2) || ((outstanding == 2) && xfer));
        chk("rom_en_rule", 32'(bus.rom_en), 32'(exp_en));
        chk("out_valid_rule", 32'(bus.out_valid), 32'(fifo_n > 0));
      end else begin
        chk("rom_en_not_busy", 32'(bus.rom_en), 32'(0));
        chk("out_valid_not_busy", 32'(bus.out_valid), 32'(0));
      end
      if (!bus.out_valid) chk("out_last_without_valid", 32'(bus.out_last), 32'(0));
      if (stall_prev) begin
        chk("stall_data_stable", 32'(bus.out_data), 32'(data_prev));
        chk("stall_last_stable", 32'(bus.out_last), 32'(last_prev));
      end
      if (bus.rom_en) begin
        if (exp_addr_q.size() == 0) begin
          chk("rom_en_unexpected", 32'(bus.rom_addr), 32'hFFFF_FFFF);
        end else begin
          a = exp_addr_q.pop_front();
          chk("rom_addr", 32'(bus.rom_addr), 32'(a));
        end
        en_cyc_log[en_count] = cyc;
        en_count++;
      end
      if (xfer) begin
        if (exp_word_q.size() == 0) begin
          chk("word_unexpected", 32'(bus.out_data), 32'hFFFF_FFFF);
        end else begin
          w = exp_word_q.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(w.data));
          chk("out_last", 32'(bus.out_last), 32'(w.last));
        end
        xfer_cyc_log[xfer_count] = cyc;
        xfer_count++;
      end
      if (bus.done) begin
        done_cyc_log[done_count] = cyc;
        done_count++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      data_prev  = bus.out_data;
      last_prev  = bus.out_last;
      en_last    = bus.rom_en;
    end
  end

  task automatic push_expect(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    word_t w;
    for (int i = 0; i < len; i++) begin
      a = AW'(base + AW'(i));
      exp_addr_q.push_back(a);
      w.data = rom[a];
      w.last = (i == len - 1);
      exp_word_q.push_back(w);
    end
  endtask

  // Called at posedge+#1; drives one burst and checks its timing at the end.
  task automatic run_burst(input logic [AW-1:0] base, input int len,
                           input int mode, input bit inject_start);
    int start_edge;
    int d0;
    int b0;
    int k;
    push_expect(base, len);
    en_base   = en_count;
    xfer_base = xfer_count;
    cur_len   = len;
    d0        = done_count;
    b0        = busy_count;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.length    = CW'(len);
    bus.out_ready = ready_for(mode, 0);
    start_edge    = cyc + 1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.base_addr = ~base;
    bus.length    = CW'(3);
    k = 1;
    for (int c = 0; c < 400 && done_count == d0; c++) begin
      bus.out_ready = ready_for(mode, k);
      bus.start     = inject_start && (k == 6);
      if (bus.start) begin
        bus.base_addr = AW'(9);
        bus.length    = CW'(2);
      end
      k++;
      @(posedge clk); #1;
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    chk("done_seen", 32'(done_count - d0), 32'(1));
    chk("words_left", 32'(exp_word_q.size()), 32'(0));
    chk("addrs_left", 32'(exp_addr_q.size()), 32'(0));
    chk("issued_count", 32'(en_count - en_base), 32'(len));
    chk("delivered_count", 32'(xfer_count - xfer_base), 32'(len));
    if (len == 0) begin
      chk("done_cycle_len0", 32'(done_cyc_log[d0]), 32'(start_edge));
      chk("busy_cycles_len0", 32'(busy_count - b0), 32'(0));
    end else begin
      chk("first_en_cycle", 32'(en_cyc_log[en_base]), 32'(start_edge));
      chk("first_word_cycle", 32'(xfer_cyc_log[xfer_base]), 32'(start_edge + 2));
      chk("done_cycle", 32'(done_cyc_log[d0]), 32'(xfer_cyc_log[xfer_base + len - 1] + 1));
      chk("busy_cycles", 32'(busy_count - b0), 32'(done_cyc_log[d0] - start_edge));
      if (mode == 0)
        chk("throughput", 32'(xfer_cyc_log[xfer_base + len - 1]), 32'(start_edge + 1 + len));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("single_done", 32'(done_count - d0), 32'(1));
    chk("no_extra_issue", 32'(en_count - en_base), 32'(len));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},      32'(bus.busy),      32'(0));
    chk({tag, "_done"},      32'(bus.done),      32'(0));
    chk({tag, "_rom_en"},    32'(bus.rom_en),    32'(0));
    chk({tag, "_rom_addr"},  32'(bus.rom_addr),  32'(0));
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(0));
    chk({tag, "_out_last"},  32'(bus.out_last),  32'(0));
    chk({tag, "_out_data"},  32'(bus.out_data),  32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_done;
    rom = '{16'h5A00, 16'h5A11, 16'h5A22, 16'h5A33, 16'h5A44, 16'h5A55, 16'h5A66, 16'h5A77,
            16'h5A88, 16'h5A99, 16'h5AAA, 16'h5ABB, 16'h5ACC, 16'h5ADD, 16'h5AEE, 16'h5AFF};
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    bus.out_ready = 1'b1;
    #3;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Burst started right after release: 3,4,5,6 back to back.
    run_burst(AW'(3), 4, 0, 1'b0);
    // Address wrap 14,15,0,1.
    run_burst(AW'(14), 4, 0, 1'b0);
    // Back-pressure 1,0,0 pattern.
    run_burst(AW'(7), 6, 1, 1'b0);
    // Empty burst.
    run_burst(AW'(0), 0, 0, 1'b0);
    // Full-depth burst with a start pulse injected mid-burst.
    run_burst(AW'(0), 16, 0, 1'b1);

    // Reset while word 3 of an 8-word burst is presented.
    snap_done = done_count;
    push_expect(AW'(5), 8);
    en_base   = en_count;
    xfer_base = xfer_count;
    cur_len   = 8;
    bus.start     = 1'b1;
    bus.base_addr = AW'(5);
    bus.length    = CW'(8);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 100 && (xfer_count - xfer_base) < 2; c++) begin
      @(posedge clk); #1;
    end
    chk("word3_presented", 32'(bus.out_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midburst_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_addr_q.delete();
    exp_word_q.delete();
    chk("post_reset_out_valid", 32'(bus.out_valid), 32'(0));
    run_burst(AW'(2), 5, 0, 1'b0);
    chk("no_done_from_abandoned", 32'(done_count - snap_done), 32'(1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rom_read_sequencer.md
ROM_READ_SEQUENCER -- requirements
Module: rom_read_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, width of the ROM word address.
REQ-002 Parameter DATA_WIDTH, default 16, width of one ROM word.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 start  input  1  request a burst; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_WIDTH  first word address of the burst; sampled with start.
REQ-007 length  input  ADDR_WIDTH+1  number of words in the burst (0..2^ADDR_WIDTH); sampled with start.
REQ-008 busy  output  1  burst in progress.
REQ-009 done  output  1  one-cycle pulse at burst completion.
REQ-010 rom_en  output  1  read strobe to the synchronous ROM.
REQ-011 rom_addr  output  ADDR_WIDTH  ROM read address, meaningful when rom_en=1.
REQ-012 rom_dout  input  DATA_WIDTH  ROM read data, valid exactly 1 cycle after the rom_en cycle.
REQ-013 out_data  output  DATA_WIDTH  word to consumer.
REQ-014 out_valid  output  1  out_data valid.
REQ-015 out_ready  input  1  consumer accepts; transfer when out_valid & out_ready.
REQ-016 out_last  output  1  qualifies the final word of the burst; only with out_valid.

Function
REQ-017 States IDLE, READ, DONE; IDLE->READ on start=1 with length!=0; IDLE->DONE on start=1 with length=0; READ->DONE on the transfer of the word with out_last=1; DONE->IDLE unconditionally after one cycle.
REQ-018 busy=1 exactly in READ; done=1 exactly in DONE; start is ignored outside IDLE.
REQ-019 Internal 2-entry FIFO holds returned ROM words; out_valid = FIFO non-empty; out_data = FIFO head.
REQ-020 rom_en=1 in READ when words remain to issue and (fifo_count + inflight < 2, or fifo_count + inflight = 2 with an output transfer in the same cycle); inflight = rom_en of the previous cycle.
REQ-021 With out_ready held high, sustained throughput is one word per cycle.
REQ-022 First rom_en is in the cycle after the start edge with rom_addr=base_addr; each subsequent issue uses rom_addr+1 modulo 2^ADDR_WIDTH (all-ones wraps to 0).
REQ-023 rom_dout is written to the FIFO at the rising edge ending the cycle after each rom_en; first out_valid is 2 cycles after the first rom_en.
REQ-024 Exactly length words are issued and delivered, in address order; none dropped, duplicated or reordered under any out_ready pattern.
REQ-025 out_data and out_last remain stable while out_valid=1 and out_ready=0.
REQ-026 Issued and delivered counters are ADDR_WIDTH+1 bits so length=2^ADDR_WIDTH is supported without overflow.
REQ-027 FIFO never overflows; a write and a read in the same cycle leave fifo_count unchanged.

Reset
REQ-028 rst_n=0 forces immediately: state IDLE, busy=0, done=0, rom_en=0, rom_addr=0, out_valid=0, out_last=0, out_data=0, FIFO empty, counters 0.
REQ-029 Reset mid-burst abandons the burst; any ROM data returning in the cycle after reset is discarded; no done pulse is produced.
REQ-030 After rst_n deasserts, the block accepts start on the first rising edge.

Verification
REQ-031 base_addr=3, length=4, out_ready=1 -> rom_addr 3,4,5,6 on 4 consecutive cycles; out_data = ROM[3..6] on 4 consecutive cycles; out_last with ROM[6]; done one cycle later.
REQ-032 base_addr=14, length=4 (ADDR_WIDTH=4) -> addresses 14,15,0,1; out_last on ROM[1].
REQ-033 length=6, out_ready toggling 1,0,0,1,... -> all 6 words delivered in order; rom_en stalls when FIFO+inflight=2; out_data stable during stalls.
REQ-034 length=0 -> no rom_en, no out_valid, busy stays 0, done pulses the cycle after the start edge.
REQ-035 length=16, base_addr=0, out_ready=1 -> 16 words ROM[0..15]; start pulsed mid-burst is ignored.
REQ-036 rst_n low for one cycle during word 3 of length=8 -> all outputs 0 immediately, no done; new start after release runs a clean burst.
